// File: rtl/writeback_queue.sv
// writeback_queue
//   In-order write-back queue between execute and the register file / PC.
//   Retired instructions are decoded once at acceptance into one of three
//   entry classes (register write, taken jump, no-op) and committed from the
//   head one per cycle as single-cycle registered strobes.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   in_valid/in_ready handshake from execute (in_ready is registered)
//   in_ir             instruction word, opcode = [15:11], rd = [10:8]
//   in_aluout         ALU result (write data / jump condition)
//   in_rtemp          load / IO data
//   in_addr           jump target
//   rf_ready          register file can take a write this cycle
//   r_en/r_select/r_data         register-write strobe, one-hot rd, data
//   pc_jump_en/pc_jump_data      PC-redirect strobe and target
//   flush             squash pulse, coincident with pc_jump_en
//   count             current occupancy
module writeback_queue #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_ir,
  input  logic [DATA_W-1:0]       in_aluout,
  input  logic [DATA_W-1:0]       in_rtemp,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    rf_ready,
  output logic                    r_en,
  output logic [NUM_REGS-1:0]     r_select,
  output logic [DATA_W-1:0]       r_data,
  output logic                    pc_jump_en,
  output logic [ADDR_W-1:0]       pc_jump_data,
  output logic                    flush,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    CL_NOP = 2'd0,
    CL_WR  = 2'd1,
    CL_JMP = 2'd2
  } cls_t;

  cls_t              q_cls  [DEPTH];
  logic [2:0]        q_rd   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_addr [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_next;

  logic [4:0]        opcode;
  logic [2:0]        rd;
  logic              rd_ok;
  cls_t              enq_cls;
  logic [DATA_W-1:0] enq_data;

  logic              nonempty;
  logic              do_wr;
  logic              do_jmp;
  logic              do_nop;
  logic              pop;
  logic              push;

  // Low byte of the instruction carries operand fields this stage never uses.
  logic unused_ir;
  assign unused_ir = ^in_ir[7:0];

  assign opcode = in_ir[15:11];
  assign rd     = in_ir[10:8];
  assign rd_ok  = ({29'd0, rd} < 32'(NUM_REGS));

  // Jumps are resolved here so the head only ever sees "taken" jumps;
  // writes to registers that do not exist collapse into no-ops.
  always_comb begin
    enq_cls  = CL_NOP;
    enq_data = '0;
    case (opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
        if (rd_ok) enq_cls = CL_WR;
        enq_data = in_aluout;
      end
      5'b00101, 5'b01000: begin
        if (rd_ok) enq_cls = CL_WR;
        enq_data = in_rtemp;
      end
      5'b00110: if (in_aluout == '0) enq_cls = CL_JMP;
      5'b01010: if (in_aluout != '0) enq_cls = CL_JMP;
      5'b00111: enq_cls = CL_JMP;
      default:  enq_cls = CL_NOP;
    endcase
  end

  assign nonempty = (count != '0);
  assign do_wr    = nonempty && (q_cls[rd_ptr] == CL_WR) && rf_ready;
  assign do_jmp   = nonempty && (q_cls[rd_ptr] == CL_JMP);
  assign do_nop   = nonempty && (q_cls[rd_ptr] == CL_NOP);
  assign pop      = do_wr || do_jmp || do_nop;
  // A taken jump also squashes whatever execute hands over in the same cycle.
  assign push     = in_valid && in_ready && !do_jmp;

  always_comb begin
    count_next = count;
    if (do_jmp) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_cls[wr_ptr]  <= enq_cls;
      q_rd[wr_ptr]   <= rd;
      q_data[wr_ptr] <= enq_data;
      q_addr[wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b0;
      r_en         <= 1'b0;
      r_select     <= '0;
      r_data       <= '0;
      pc_jump_en   <= 1'b0;
      pc_jump_data <= '0;
      flush        <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != CNT_W'(DEPTH));

      if (do_jmp) begin
        // Drop everything behind the head: both pointers land just past it.
        rd_ptr <= rd_ptr + PTR_W'(1);
        wr_ptr <= rd_ptr + PTR_W'(1);
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      end

      r_en <= do_wr;
      if (do_wr) begin
        r_select <= NUM_REGS'(1) << q_rd[rd_ptr];
        r_data   <= q_data[rd_ptr];
      end

      pc_jump_en <= do_jmp;
      flush      <= do_jmp;
      if (do_jmp) pc_jump_data <= q_addr[rd_ptr];
    end
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Parametrised successor to the single-shot write-back stage of the RISC pipeline.
- Accepts retired instructions from execute over a valid/ready handshake and buffers them in an in-order queue of DEPTH entries.
- Commits each entry as a one-cycle register-file write pulse or a PC-redirect pulse.
- Adds over the previous stage: register-file back-pressure, a conditional-not-zero jump (JNZ), a one-hot register select of configurable width, and a flush after every taken jump.

Parameters:
- DATA_W, 8, register/ALU data width.
- ADDR_W, 16, PC/jump-address width.
- NUM_REGS, 8, register count; width of one-hot select; rd field = IR[10:8] (NUM_REGS ≤ 8).
- DEPTH, 4, queue entries (power of 2, ≥ 2).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  execute presents a retired instruction.
- in_ready  out  1  queue can accept; transfer happens when in_valid & in_ready.
- in_ir  in  16  instruction word; opcode = IR[15:11], rd = IR[10:8].
- in_aluout  in  DATA_W  ALU result.
- in_rtemp  in  DATA_W  memory/IO load data.
- in_addr  in  ADDR_W  jump target.
- rf_ready  in  1  register file accepts a write this cycle.
- r_en  out  1  register-write strobe (one cycle per commit).
- r_select  out  NUM_REGS  one-hot destination, valid while r_en.
- r_data  out  DATA_W  write data, valid while r_en.
- pc_jump_en  out  1  PC-redirect strobe (one cycle).
- pc_jump_data  out  ADDR_W  redirect target, valid while pc_jump_en.
- flush  out  1  one-cycle pulse coincident with pc_jump_en; upstream squashes younger work.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0 at posedge): queue emptied, pointers = 0, count = 0. r_en, pc_jump_en, flush = 0. r_select, r_data, pc_jump_data = 0. in_ready = 0 during the reset cycle and 1 from the first cycle after. Reset mid-operation discards all queued entries; no partial commit.
- Enqueue decode (at accept): opcode selects the class.
  - WR_ALU: 00000 ADD, 00001 SUB, 00010 MOV, 00011 MVI. Data = in_aluout.
  - WR_TMP: 00101 LDA, 01000 IN. Data = in_rtemp.
  - JZ: 00110. Taken if in_aluout == 0.
  - JNZ: 01010. Taken if in_aluout != 0.
  - JMP: 00111. Always taken.
  - Everything else (incl. 01001 OUT): NOP.
- Entry contents: {class, rd, data, addr, taken}. Taken is resolved at enqueue. Not-taken jumps and NOPs are stored as NOP.
- NOP entries are retained, so commits stay in order and count reflects accepted transfers.
- in_ready = !full, registered from occupancy; no combinational path from rf_ready.
- Commit (one entry per cycle, head only):
  - Write entry: commits only when rf_ready = 1. The next cycle drives r_en = 1, r_select = 1<<rd, r_data = data. If rf_ready = 0 the head stalls and later entries wait.
  - Taken jump: commits unconditionally. The next cycle drives pc_jump_en = 1, flush = 1, pc_jump_data = addr. In the same cycle as the commit, all entries behind the head are dropped (count → 0, plus any same-cycle enqueue is also dropped).
  - NOP: popped in one cycle, no strobe.
- Commit latency: an accepted entry into an empty queue with rf_ready = 1 produces its strobe 2 cycles after acceptance (1 cycle to write, 1 cycle registered output).
- Strobes are single-cycle. All outputs are registered. r_select/r_data hold their last value when r_en = 0.
- Simultaneous enqueue and dequeue: allowed when full (in_ready was 0, so no enqueue) or otherwise. Count is unchanged on push + pop.
- Pointers wrap modulo DEPTH. Full is when count == DEPTH; empty is when count == 0.
- rd ≥ NUM_REGS: the write is discarded (treated as NOP) and no strobe is issued.

Test Plan:
- Reset then single ADD: IR=0x0300 (rd=3), aluout=0x5A, rf_ready=1 → two cycles later r_en=1, r_select=8'b00001000, r_data=0x5A for exactly one cycle.
- Back-pressure fill: hold rf_ready=0 and push 4 LDA entries (rtemp 0x11..0x14, rd 0..3) → count=4, in_ready=0. Release rf_ready → four consecutive r_en pulses, data 0x11,0x12,0x13,0x14, in order. in_ready returns to 1 after the first pop.
- Conditional jumps: JZ with aluout=0x00, addr=0x1234 → pc_jump_en=1, pc_jump_data=0x1234, flush=1. JZ with aluout=0x01 → no strobe. JNZ with aluout=0x01, addr=0x00FF → jump to 0x00FF.
- Flush squash: queue [JMP 0x0040, MOV rd=1, ADD rd=2] with rf_ready=1 → one pc_jump_en to 0x0040, no r_en afterwards, count=0.
- Reset mid-operation: queue holds 3 entries with rf_ready=0, assert rst_n=0 for one cycle → count=0, no strobes after release, in_ready=1 next cycle.
- NOP and wrap: push 9 OUT instructions (IR=0x4800) interleaved with MVI rd=7 data 0xA5, DEPTH=4 → no strobe for OUT, each MVI gives r_select=8'b10000000, r_data=0xA5. Pointers wrap without loss.
